alu_issue_stage: RTL
====================

# alu_issue_stage

Operand-fetch and issue stage that sits directly upstream of `ALU`. It accepts one instruction per cycle over a valid/ready handshake and reads operands from an internal register file or an immediate. It drives registered operands, carry, opcode and mode into `ALU`, then writes the combinational ALU result and flags back on the following clock edge. Result/carry forwarding lets dependent instructions issue back-to-back with no stalls.

## Interface
Types `DATA_WIDTH`, `enum_alu_opcode_t` and `struct_alu_flag_t` come from `CPU_package`.

Parameters:
- `REG_COUNT`, default 8: number of register-file entries. Power of two, ≥2.
- `REG_ADDR_W`, default `$clog2(REG_COUNT)`: register index width.

Ports (name, direction, width, meaning):
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `instr_valid`, input, 1: an instruction is presented.
- `instr_ready`, output, 1: stage accepts the instruction this cycle. Equals `!host_wr_en`.
- `instr_opcode`, input, `enum_alu_opcode_t`: opcode passed to the ALU.
- `instr_mode`, input, 1: ALU mode (0 = logic, 1 = arithmetic).
- `instr_rs_a`, `instr_rs_b`, `instr_rd`, input, `REG_ADDR_W` each: source A, source B and destination register indices.
- `instr_use_imm`, input, 1: B operand is `instr_imm` instead of `rf[instr_rs_b]`.
- `instr_imm`, input, `DATA_WIDTH`: immediate value.
- `instr_use_carry`, input, 1: carry-in is the current carry flag; otherwise carry-in is 0.
- `host_wr_en`, input, 1: host register-file write request.
- `host_wr_addr`, input, `REG_ADDR_W`: host write index.
- `host_wr_data`, input, `DATA_WIDTH`: host write data.
- `dbg_addr`, input, `REG_ADDR_W`: debug read index.
- `dbg_data`, output, `DATA_WIDTH`: combinational `rf[dbg_addr]`; no forwarding.
- `in_a`, `in_b`, output, `DATA_WIDTH` each: registered operands to the ALU.
- `input_carry`, output, 1: registered carry-in to the ALU.
- `alu_opcode`, output, `enum_alu_opcode_t`: registered opcode.
- `mode`, output, 1: registered mode.
- `issue_valid`, output, 1: the ALU holds a live instruction this cycle.
- `alu_out`, input, `DATA_WIDTH`: ALU result (combinational from the outputs above).
- `alu_out_flag`, input, `struct_alu_flag_t`: ALU flags. Bit 0 of the packed struct is the carry flag.
- `flag_q`, output, `struct_alu_flag_t`: architectural flag register.

## Operation
Reset (asynchronous, while `rst_n` = 0):
- All `rf` entries, `flag_q`, `in_a`, `in_b`, `input_carry`, `mode` and `issue_valid` are 0.
- `alu_opcode` = `enum_alu_opcode_t'(0)`.
- Internal `wb_rd` = 0.

Accept:
- An instruction is accepted on an edge where `instr_valid && instr_ready`.
- On accept, the issue register loads the operands, carry, opcode, mode and `wb_rd = instr_rd`, and sets `issue_valid` = 1.
- With no accept, `issue_valid` goes to 0 and the other issue-register fields hold their values.

Operand select, with priority:
1. Forward: if `issue_valid` and the source index equals `wb_rd`, the operand is `alu_out`.
2. Otherwise the operand is `rf[src]`.

- When `instr_use_imm` = 1, B is `instr_imm` and no forwarding applies to B.
- Carry-in: if `instr_use_carry` = 0, carry-in is 0. Otherwise it is `alu_out_flag[0]` when `issue_valid`, else `flag_q[0]`.

Writeback:
- On every edge with `issue_valid` = 1: `rf[wb_rd] <= alu_out` and `flag_q <= alu_out_flag`.
- Every issued instruction updates all flags.

Host write:
- `host_wr_en` forces `instr_ready` = 0, so there is no accept that cycle.
- The in-flight writeback still completes.
- If the writeback and the host write target the same index on the same edge, the host data wins.

Reset mid-operation:
- The in-flight instruction is discarded with no rf or flag update.
- An instruction presented during reset is not accepted.

## Timing
- Issue latency: the instruction is accepted at edge N. The ALU inputs are valid in cycle N..N+1 with `issue_valid` = 1. Writeback happens at edge N+1.
- Throughput: 1 instruction per cycle. There are no hazard stalls, because forwarding covers the only in-flight producer.
- A writeback at edge N+1 is visible via `rf` reads from cycle N+1 onward.
- `dbg_data` reflects writebacks one cycle after the write edge.
- `instr_ready` is a combinational function of `host_wr_en` only.
- Same-index `instr_rs_a`/`instr_rs_b` and `instr_rd` are legal. Reads use the old value or the forwarded value; the write lands at the next edge.

## Test plan
- Reset check: assert `rst_n` = 0 mid-run with `issue_valid` = 1. Required response: all outputs reach their reset values immediately, `dbg_data` = 0 for every index, and no writeback occurs after release.
- Basic add: host writes r1 = 5 and r2 = 3, then the add opcode with mode = 1, rs_a = 1, rs_b = 2, rd = 3. Required response: next cycle `in_a` = 5, `in_b` = 3 and `issue_valid` = 1; one cycle later `dbg_data`(r3) = 8.
- Back-to-back forwarding: r3 = r1 + r2 immediately followed by r4 = r3 + r1. Required response: the second issue shows `in_a` = 8 (forwarded) and `in_b` = 5, and r4 ends at 13.
- Immediate and carry chain: r1 = `{DATA_WIDTH{1'b1}}`, then an add with imm = 1 into r5, then an add with use_carry = 1 of r0 + imm 0 into r6. Required response: r5 = 0, `input_carry` = 1 on the second issue, r6 = 1.
- Host stall collision: `host_wr_en` to r3 in the same cycle as an in-flight writeback to r3, with `instr_valid` = 1. Required response: `instr_ready` = 0, r3 = host data, and the presented instruction issues the following cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue stage feeding a combinational ALU.
// Holds the register file and the architectural flags, registers one
// instruction per cycle into the ALU inputs, and writes the ALU result back
// on the following edge. Forwarding from the in-flight instruction removes
// all read-after-write stalls.

package CPU_package;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } enum_alu_opcode_t;

  // Carry is the last member so it lands on bit 0 of the packed struct.
  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
    logic carry;
  } struct_alu_flag_t;
endpackage

module alu_issue_stage
  import CPU_package::*;
#(
  parameter int REG_COUNT  = 8,
  parameter int REG_ADDR_W = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  enum_alu_opcode_t      instr_opcode,
  input  logic                  instr_mode,
  input  logic [REG_ADDR_W-1:0] instr_rs_a,
  input  logic [REG_ADDR_W-1:0] instr_rs_b,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic                  instr_use_imm,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  input  logic                  instr_use_carry,
  input  logic                  host_wr_en,
  input  logic [REG_ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [DATA_WIDTH-1:0] in_a,
  output logic [DATA_WIDTH-1:0] in_b,
  output logic                  input_carry,
  output enum_alu_opcode_t      alu_opcode,
  output logic                  mode,
  output logic                  issue_valid,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  struct_alu_flag_t      alu_out_flag,
  output struct_alu_flag_t      flag_q
);

  logic [DATA_WIDTH-1:0] rf [REG_COUNT];
  logic [REG_ADDR_W-1:0] wb_rd_reg;

  logic                  accept;
  logic                  fwd_a;
  logic                  fwd_b;
  logic [DATA_WIDTH-1:0] opnd_a_next;
  logic [DATA_WIDTH-1:0] opnd_b_next;
  logic                  carry_next;

  // Per-entry write selects; host write takes precedence over writeback.
  logic [REG_COUNT-1:0]  host_sel;
  logic [REG_COUNT-1:0]  wb_sel;

  // A host write steals the register-file write port, so it blocks issue.
  assign instr_ready = !host_wr_en;
  assign accept      = instr_valid && instr_ready;

  // Debug port sees only committed register state.
  assign dbg_data = rf[dbg_addr];

  // Operand selection: forward the in-flight result when it targets the source.
  always_comb begin
    fwd_a       = issue_valid && (instr_rs_a == wb_rd_reg);
    fwd_b       = issue_valid && (instr_rs_b == wb_rd_reg) && !instr_use_imm;
    opnd_a_next = fwd_a ? alu_out : rf[instr_rs_a];
    if (instr_use_imm) begin
      opnd_b_next = instr_imm;
    end else if (fwd_b) begin
      opnd_b_next = alu_out;
    end else begin
      opnd_b_next = rf[instr_rs_b];
    end
    // Carry also forwards from the in-flight instruction.
    carry_next = instr_use_carry && (issue_valid ? alu_out_flag[0] : flag_q[0]);
  end

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_wr_sel
      assign host_sel[gi] = host_wr_en && (host_wr_addr == REG_ADDR_W'(gi));
      assign wb_sel[gi]   = issue_valid && (wb_rd_reg == REG_ADDR_W'(gi));
    end
  endgenerate

  // Issue register: loads on accept, otherwise holds fields and drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_a        <= '0;
      in_b        <= '0;
      input_carry <= 1'b0;
      alu_opcode  <= enum_alu_opcode_t'(0);
      mode        <= 1'b0;
      wb_rd_reg   <= '0;
      issue_valid <= 1'b0;
    end else begin
      issue_valid <= accept;
      if (accept) begin
        in_a        <= opnd_a_next;
        in_b        <= opnd_b_next;
        input_carry <= carry_next;
        alu_opcode  <= instr_opcode;
        mode        <= instr_mode;
        wb_rd_reg   <= instr_rd;
      end
    end
  end

  // Register file: host write wins over a same-index writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (host_sel[i]) begin
          rf[i] <= host_wr_data;
        end else if (wb_sel[i]) begin
          rf[i] <= alu_out;
        end
      end
    end
  end

  // Architectural flags follow every retired instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
    end else if (issue_valid) begin
      flag_q <= alu_out_flag;
    end
  end

endmodule
